// File: rtl/neo_spike_detector.sv
// NEO spike detector.
// Learns an adaptive threshold (K x mean of the first M clamped NEO samples).
// It then flags accepted samples above that threshold, with a refractory
// hold-off counted in accepted samples.
module neo_spike_detector #(
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int K      = 4,
    parameter int REFRAC = 3
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    neo_valid,
    output logic                    neo_ready,
    input  logic signed [N-1:0]     neo_data,
    input  logic [$clog2(M):0]      neo_addr,
    input  logic                    recal,
    output logic                    spike,
    output logic [$clog2(M):0]      spike_addr,
    output logic [N+$clog2(K):0]    thr,
    output logic                    thr_valid
);

    localparam int LG   = $clog2(M);
    localparam int ACCW = N + LG;
    localparam int THRW = N + $clog2(K) + 1;
    localparam int RW   = $clog2(REFRAC + 1) + 1;

    typedef enum logic [1:0] {
        CALIB,
        THRESH,
        DETECT
    } state_t;

    state_t            state;
    logic [ACCW-1:0]   acc;
    logic [LG:0]       cnt;
    logic [RW-1:0]     rcnt;

    logic              accept;
    logic [N-1:0]      clamped;
    logic [N-1:0]      mean;
    logic [THRW-1:0]   thr_next;
    logic [THRW-1:0]   data_ext;
    logic              trigger;

    // Datapath helpers: acceptance, clamping, mean/threshold and trigger test.
    always_comb begin
        accept   = neo_valid && neo_ready;
        clamped  = neo_data[N-1] ? '0 : neo_data;
        mean     = acc[ACCW-1:LG];
        thr_next = THRW'(mean) * THRW'(K);
        data_ext = {{(THRW-N){1'b0}}, neo_data};
        trigger  = !neo_data[N-1] && (neo_data != '0) && (data_ext > thr);
    end

    // Control FSM with registered outputs; recal overrides any acceptance.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= CALIB;
            acc        <= '0;
            cnt        <= '0;
            rcnt       <= '0;
            spike      <= 1'b0;
            spike_addr <= '0;
            thr        <= '0;
            thr_valid  <= 1'b0;
            neo_ready  <= 1'b1;
        end else begin
            spike <= 1'b0;
            if (recal) begin
                state     <= CALIB;
                acc       <= '0;
                cnt       <= '0;
                rcnt      <= '0;
                thr_valid <= 1'b0;
                neo_ready <= 1'b1;
            end else begin
                case (state)
                    CALIB: begin
                        if (accept) begin
                            acc <= acc + ACCW'(clamped);
                            if (cnt == (LG+1)'(M - 1)) begin
                                state     <= THRESH;
                                neo_ready <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    THRESH: begin
                        thr       <= thr_next;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= DETECT;
                        neo_ready <= 1'b1;
                        thr_valid <= 1'b1;
                    end
                    DETECT: begin
                        if (accept) begin
                            if (rcnt != '0) begin
                                rcnt <= rcnt - 1'b1;
                            end else if (trigger) begin
                                spike      <= 1'b1;
                                spike_addr <= neo_addr;
                                rcnt       <= RW'(REFRAC);
                            end
                        end
                    end
                    default: begin
                        state     <= CALIB;
                        neo_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Testbench for neo_spike_detector: directed scenarios plus random traffic,
// checked every cycle against a behavioural model through a scoreboard queue.
module tb_neo_spike_detector;

    localparam int N      = 8;
    localparam int M      = 8;
    localparam int K      = 4;
    localparam int REFRAC = 3;
    localparam int AW     = $clog2(M) + 1;
    localparam int THRW   = N + $clog2(K) + 1;

    logic                 Clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 neo_valid = 1'b0;
    logic                 neo_ready;
    logic signed [N-1:0]  neo_data = '0;
    logic [AW-1:0]        neo_addr = '0;
    logic                 recal = 1'b0;
    logic                 spike;
    logic [AW-1:0]        spike_addr;
    logic [THRW-1:0]      thr;
    logic                 thr_valid;

    neo_spike_detector #(.N(N), .M(M), .K(K), .REFRAC(REFRAC)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .neo_valid  (neo_valid),
        .neo_ready  (neo_ready),
        .neo_data   (neo_data),
        .neo_addr   (neo_addr),
        .recal      (recal),
        .spike      (spike),
        .spike_addr (spike_addr),
        .thr        (thr),
        .thr_valid  (thr_valid)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int spk_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    typedef struct {
        bit spk;
        int addr;
        int thr;
        bit tv;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    int   cal_q[$];
    bit   m_detect = 0, m_pend = 0, m_ready = 1, m_tv = 0, m_spk = 0;
    int   m_thr = 0, m_addr = 0, m_refr = 0, m_acc = 0;

    task automatic model_reset();
        cal_q.delete();
        m_detect = 0; m_pend = 0; m_ready = 1; m_tv = 0; m_spk = 0;
        m_thr = 0; m_addr = 0; m_refr = 0;
    endtask

    task automatic model_push();
        exp_t e;
        e.spk = m_spk; e.addr = m_addr; e.thr = m_thr; e.tv = m_tv; e.rdy = m_ready;
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        int d, sum;
        m_spk = 0;
        if (recal) begin
            cal_q.delete();
            m_detect = 0; m_pend = 0; m_refr = 0; m_tv = 0; m_ready = 1;
        end else if (m_pend) begin
            sum = 0;
            foreach (cal_q[i]) sum += cal_q[i];
            m_thr = (sum / M) * K;
            cal_q.delete();
            m_pend = 0; m_detect = 1; m_tv = 1; m_ready = 1;
        end else if (neo_valid && m_ready) begin
            m_acc++;
            d = int'(neo_data);
            if (!m_detect) begin
                cal_q.push_back(d < 0 ? 0 : d);
                if (cal_q.size() == M) begin
                    m_pend = 1; m_ready = 0;
                end
            end else if (m_refr > 0) begin
                m_refr--;
            end else if (d > m_thr) begin
                m_spk = 1; m_addr = int'(neo_addr); m_refr = REFRAC;
            end
        end
    endtask

    // Model advances on each rising edge from the driven inputs.
    always @(posedge Clk) begin
        if (!reset) model_reset();
        else model_step();
        model_push();
    end

    // Asynchronous reset clears the model and drops stale expectations.
    always @(negedge reset) begin
        model_reset();
        exp_q.delete();
    end

    // Monitor: pop one expectation per cycle and compare all outputs.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (spike) spk_seen++;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("spike", int'(spike), int'(e.spk));
            chk("spike_addr", int'(spike_addr), e.addr);
            chk("thr", int'(thr), e.thr);
            chk("thr_valid", int'(thr_valid), int'(e.tv));
            chk("neo_ready", int'(neo_ready), int'(e.rdy));
        end
    end

    // ---------------- stimulus helpers (start and end on a falling edge) ----
    task automatic gap(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive_sample(input int d, input int a);
        int start;
        bit done;
        start = m_acc;
        done = 0;
        neo_valid = 1'b1;
        neo_data  = N'(d);
        neo_addr  = AW'(a);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge Clk);
            if (m_acc != start) done = 1;
        end
        neo_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic recal_pulse(input bit v, input int d);
        recal     = 1'b1;
        neo_valid = v;
        neo_data  = N'(d);
        @(negedge Clk);
        recal     = 1'b0;
        neo_valid = 1'b0;
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int cal_a[8] = '{-20, -20, -20, -20, 16, 16, 16, 17};

        // Reset state
        gap(2);
        chk("rst_spike", int'(spike), 0);
        chk("rst_thr", int'(thr), 0);
        chk("rst_thr_valid", int'(thr_valid), 0);
        chk("rst_ready", int'(neo_ready), 1);
        reset = 1'b1;
        gap(1);

        // Calibration with 8 x 10
        for (int i = 0; i < 8; i++) drive_sample(10, i);
        chk("thresh_ready", int'(neo_ready), 0);
        chk("thresh_thr_valid", int'(thr_valid), 0);
        gap(1);
        chk("cal_thr", int'(thr), 40);
        chk("cal_thr_valid", int'(thr_valid), 1);
        chk("cal_ready", int'(neo_ready), 1);

        // Threshold edge
        drive_sample(40, 1);
        chk("eq_no_spike", int'(spike), 0);
        drive_sample(41, 5);
        chk("gt_spike", int'(spike), 1);
        chk("gt_addr", int'(spike_addr), 5);
        gap(1);
        chk("spike_one_cycle", int'(spike), 0);

        // Refractory, back-to-back then with 2-cycle gaps
        for (int i = 0; i < 3; i++) drive_sample(0, 0);
        s0 = spk_seen;
        for (int i = 0; i < 6; i++) drive_sample(50, 8 + i);
        gap(1);
        chk("refrac_count", spk_seen - s0, 2);
        chk("refrac_addr", int'(spike_addr), 12);
        for (int i = 0; i < 2; i++) drive_sample(0, 0);
        s0 = spk_seen;
        for (int i = 0; i < 6; i++) begin
            drive_sample(50, 2 + i);
            gap(2);
        end
        chk("refrac_gap_count", spk_seen - s0, 2);
        chk("refrac_gap_addr", int'(spike_addr), 6);
        for (int i = 0; i < 2; i++) drive_sample(0, 0);

        // Recal with a simultaneous sample of 100
        recal_pulse(1'b1, 100);
        chk("recal_no_spike", int'(spike), 0);
        chk("recal_thr_valid", int'(thr_valid), 0);
        chk("recal_thr_kept", int'(thr), 40);
        for (int i = 0; i < 8; i++) drive_sample(2, i);
        gap(1);
        chk("recal_thr", int'(thr), 8);

        // Negative clamp and truncation
        recal_pulse(1'b0, 0);
        for (int i = 0; i < 8; i++) drive_sample(cal_a[i], i);
        gap(1);
        chk("clamp_thr", int'(thr), 32);
        drive_sample(-100, 3);
        chk("neg_no_spike", int'(spike), 0);

        // Reset mid-calibration
        recal_pulse(1'b0, 0);
        for (int i = 0; i < 5; i++) drive_sample(50, i);
        @(posedge Clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_thr", int'(thr), 0);
        chk("arst_spike_addr", int'(spike_addr), 0);
        chk("arst_thr_valid", int'(thr_valid), 0);
        chk("arst_ready", int'(neo_ready), 1);
        chk("arst_spike", int'(spike), 0);
        @(negedge Clk);
        reset = 1'b1;
        gap(1);
        for (int i = 0; i < 8; i++) drive_sample(10, i);
        gap(1);
        chk("arst_recal_thr", int'(thr), 40);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 39));
            if (r == 0) recal_pulse(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
            else if (r < 8) gap(1);
            else if (!m_ready) gap(1);
            else if (!m_detect) drive_sample(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 15)));
            else drive_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)));
        end
        gap(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
